// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared constants, state enum and helpers for the eth transmit arbiter
//
// Contents:
//   REQ_*        requester index of each packet source (index 0 = highest priority)
//   arb_state_e  arbiter state encoding
//   sat_inc8     saturating 8-bit increment used by the error counter
package eth_pkg;

  localparam int REQ_ARP_RESP = 0;
  localparam int REQ_ARP_REQ  = 1;
  localparam int REQ_UDP      = 2;
  localparam int REQ_CMD_ACK  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_BUSY  = 2'd2,
    ST_GAP   = 2'd3
  } arb_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/eth_prio_pick.sv
// rtl/eth_prio_pick.sv - combinational lowest-index one-hot picker
//
// Ports:
//   i_vec     in   N  candidate vector
//   o_onehot  out  N  lowest set bit of i_vec, or 0 when i_vec is 0
module eth_prio_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] i_vec,
  output logic [N-1:0] o_onehot
);

  // Two's-complement trick: v & -v isolates the lowest set bit.
  assign o_onehot = i_vec & (~i_vec + {{(N-1){1'b0}}, 1'b1});

endmodule

// File: rtl/eth_tx_arbiter.sv
// rtl/eth_tx_arbiter.sv - packet-granular arbiter sharing the eth_send transmit path
//
// Ports:
//   clk        in   1     system clock
//   rst_n      in   1     asynchronous active-low reset
//   i_req      in   NREQ  level request per source, held until its o_ack bit
//   i_tx_sop   in   1     start-of-packet pulse from eth_send
//   i_tx_eop   in   1     end-of-packet pulse from eth_send
//   o_gnt      out  NREQ  one-hot grant driving the eth_send type/target mux
//   o_gnt_vld  out  1     a grant is held (GRANT or BUSY)
//   o_ack      out  NREQ  one-cycle pulse on the granted bit after sop
//   o_done     out  NREQ  one-cycle pulse on the granted bit after eop
//   o_abort    out  1     one-cycle pulse when the watchdog fires
//   o_err_cnt  out  8     saturating count of aborts plus spurious sops
module eth_tx_arbiter
  import eth_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int STARVE_LIM = 8,
  parameter int WDOG_CYC   = 200000,
  parameter int GAP_CYC    = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_tx_sop,
  input  logic            i_tx_eop,
  output logic [NREQ-1:0] o_gnt,
  output logic            o_gnt_vld,
  output logic [NREQ-1:0] o_ack,
  output logic [NREQ-1:0] o_done,
  output logic            o_abort,
  output logic [7:0]      o_err_cnt
);

  localparam int WDW = $clog2(WDOG_CYC + 1);
  localparam int GPW = $clog2(GAP_CYC + 1);
  localparam int STW = $clog2(STARVE_LIM + 1);

  localparam logic [WDW-1:0] WDOG_LAST  = WDW'(WDOG_CYC);
  localparam logic [GPW-1:0] GAP_LAST   = GPW'(GAP_CYC - 1);
  localparam logic [STW-1:0] STARVE_MAX = STW'(STARVE_LIM);

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] req_q, req_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            gnt_vld_q, gnt_vld_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            abort_q, abort_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic [WDW-1:0]  wdog_q, wdog_d;
  logic [GPW-1:0]  gap_q, gap_d;
  logic [STW-1:0]  wait_q [NREQ];
  logic [STW-1:0]  wait_d [NREQ];

  logic [NREQ-1:0] starved;
  logic [NREQ-1:0] starved_pick;
  logic [NREQ-1:0] active_pick;
  logic [NREQ-1:0] winner;

  // Requests are registered once so that arbitration never depends
  // combinationally on the sources; this is the first of the two
  // request-to-grant cycles.
  always_comb begin
    starved = '0;
    for (int i = 0; i < NREQ; i++) begin
      starved[i] = req_q[i] && (wait_q[i] >= STARVE_MAX);
    end
  end

  eth_prio_pick #(.N(NREQ)) u_pick_starved (
    .i_vec    (starved),
    .o_onehot (starved_pick)
  );

  eth_prio_pick #(.N(NREQ)) u_pick_active (
    .i_vec    (req_q),
    .o_onehot (active_pick)
  );

  assign winner = (|starved) ? starved_pick : active_pick;

  always_comb begin
    state_d   = state_q;
    req_d     = i_req;
    gnt_d     = gnt_q;
    gnt_vld_d = gnt_vld_q;
    ack_d     = '0;
    done_d    = '0;
    abort_d   = 1'b0;
    err_cnt_d = err_cnt_q;
    wdog_d    = wdog_q;
    gap_d     = gap_q;
    for (int i = 0; i < NREQ; i++) begin
      wait_d[i] = wait_q[i];
    end

    case (state_q)
      ST_IDLE: begin
        if (i_tx_sop) begin
          err_cnt_d = sat_inc8(err_cnt_q);
        end
        if (|req_q) begin
          state_d   = ST_GRANT;
          gnt_d     = winner;
          gnt_vld_d = 1'b1;
          wdog_d    = '0;
          for (int i = 0; i < NREQ; i++) begin
            if (winner[i]) wait_d[i] = '0;
          end
        end
      end

      ST_GRANT: begin
        if (i_tx_sop) begin
          ack_d  = gnt_q;
          wdog_d = '0;
          // Every other pending source has now lost one more packet.
          for (int i = 0; i < NREQ; i++) begin
            if (!gnt_q[i] && req_q[i] && (wait_q[i] < STARVE_MAX)) begin
              wait_d[i] = wait_q[i] + STW'(1);
            end
          end
          if (i_tx_eop) begin
            done_d    = gnt_q;
            gnt_d     = '0;
            gnt_vld_d = 1'b0;
            gap_d     = '0;
            state_d   = ST_GAP;
          end else begin
            state_d = ST_BUSY;
          end
        end else if ((req_q & gnt_q) == '0) begin
          // Source withdrew before eth_send started: release silently.
          gnt_d     = '0;
          gnt_vld_d = 1'b0;
          state_d   = ST_IDLE;
        end else if (wdog_q == WDOG_LAST) begin
          abort_d   = 1'b1;
          gnt_d     = '0;
          gnt_vld_d = 1'b0;
          err_cnt_d = sat_inc8(err_cnt_q);
          gap_d     = '0;
          state_d   = ST_GAP;
        end else begin
          wdog_d = wdog_q + WDW'(1);
        end
      end

      ST_BUSY: begin
        if (i_tx_eop) begin
          done_d    = gnt_q;
          gnt_d     = '0;
          gnt_vld_d = 1'b0;
          gap_d     = '0;
          state_d   = ST_GAP;
        end else if (wdog_q == WDOG_LAST) begin
          abort_d   = 1'b1;
          gnt_d     = '0;
          gnt_vld_d = 1'b0;
          err_cnt_d = sat_inc8(err_cnt_q);
          gap_d     = '0;
          state_d   = ST_GAP;
        end else begin
          wdog_d = wdog_q + WDW'(1);
        end
      end

      ST_GAP: begin
        if (i_tx_sop) begin
          err_cnt_d = sat_inc8(err_cnt_q);
        end
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + GPW'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      req_q     <= '0;
      gnt_q     <= '0;
      gnt_vld_q <= 1'b0;
      ack_q     <= '0;
      done_q    <= '0;
      abort_q   <= 1'b0;
      err_cnt_q <= '0;
      wdog_q    <= '0;
      gap_q     <= '0;
      for (int i = 0; i < NREQ; i++) begin
        wait_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      gnt_q     <= gnt_d;
      gnt_vld_q <= gnt_vld_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
      err_cnt_q <= err_cnt_d;
      wdog_q    <= wdog_d;
      gap_q     <= gap_d;
      for (int i = 0; i < NREQ; i++) begin
        wait_q[i] <= wait_d[i];
      end
    end
  end

  assign o_gnt     = gnt_q;
  assign o_gnt_vld = gnt_vld_q;
  assign o_ack     = ack_q;
  assign o_done    = done_q;
  assign o_abort   = abort_q;
  assign o_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb/tb_eth_tx_arbiter.sv - directed self-checking bench for eth_tx_arbiter
module tb_eth_tx_arbiter;
  import eth_pkg::*;

  localparam int NREQ  = 4;
  localparam int SLIM  = 8;
  localparam int WDOG  = 100;
  localparam int GAP   = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NREQ-1:0] i_req = '0;
  logic            i_tx_sop = 1'b0;
  logic            i_tx_eop = 1'b0;
  logic [NREQ-1:0] o_gnt;
  logic            o_gnt_vld;
  logic [NREQ-1:0] o_ack;
  logic [NREQ-1:0] o_done;
  logic            o_abort;
  logic [7:0]      o_err_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  eth_tx_arbiter #(
    .NREQ       (NREQ),
    .STARVE_LIM (SLIM),
    .WDOG_CYC   (WDOG),
    .GAP_CYC    (GAP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (i_req),
    .i_tx_sop  (i_tx_sop),
    .i_tx_eop  (i_tx_eop),
    .o_gnt     (o_gnt),
    .o_gnt_vld (o_gnt_vld),
    .o_ack     (o_ack),
    .o_done    (o_done),
    .o_abort   (o_abort),
    .o_err_cnt (o_err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(output int n);
    n = 0;
    while (o_gnt == '0 && n < 200) begin
      step();
      n++;
    end
  endtask

  // Runs one packet on the current grant; the source drops its request on ack.
  task automatic do_pkt(output logic [NREQ-1:0] ack, output logic [NREQ-1:0] done);
    i_tx_sop = 1'b1;
    step();
    i_tx_sop = 1'b0;
    ack = o_ack;
    i_req = i_req & ~ack;
    step();
    step();
    i_tx_eop = 1'b1;
    step();
    i_tx_eop = 1'b0;
    done = o_done;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    int n;
    logic [NREQ-1:0] a, d;
    logic done_seen;

    // Reset state
    step();
    step();
    check("rst_gnt", o_gnt, 0);
    check("rst_vld", o_gnt_vld, 0);
    check("rst_ack", o_ack, 0);
    check("rst_done", o_done, 0);
    check("rst_abort", o_abort, 0);
    check("rst_err", o_err_cnt, 0);
    rst_n = 1'b1;
    step();

    // Single source grant
    i_req = 4'b0100;
    step();
    check("t1_gnt_early", o_gnt, 0);
    step();
    check("t1_gnt", o_gnt, 4'b0100);
    check("t1_vld", o_gnt_vld, 1);
    step();
    step();
    check("t1_gnt_hold", o_gnt, 4'b0100);
    i_tx_sop = 1'b1;
    step();
    i_tx_sop = 1'b0;
    check("t1_ack", o_ack, 4'b0100);
    check("t1_no_done", o_done, 0);
    i_req = '0;
    step();
    check("t1_ack_pulse", o_ack, 0);
    check("t1_busy_gnt", o_gnt, 4'b0100);
    step();
    i_tx_eop = 1'b1;
    step();
    i_tx_eop = 1'b0;
    check("t1_done", o_done, 4'b0100);
    check("t1_gnt_clr", o_gnt, 0);
    check("t1_vld_clr", o_gnt_vld, 0);
    i_req = 4'b0100;
    wait_gnt(n);
    check("t1_spacing", n, 17);
    check("t1_regnt", o_gnt, 4'b0100);

    // Request drop before sop
    i_req = '0;
    step();
    check("drop_hold", o_gnt, 4'b0100);
    step();
    check("drop_gnt", o_gnt, 0);
    check("drop_vld", o_gnt_vld, 0);
    check("drop_ack", o_ack, 0);
    step();

    // Fixed priority
    i_req = 4'b0110;
    wait_gnt(n);
    check("t2_gnt1", o_gnt, 4'b0010);
    do_pkt(a, d);
    check("t2_ack1", a, 4'b0010);
    check("t2_done1", d, 4'b0010);
    check("t2_wait2", dut.wait_q[2], 1);
    wait_gnt(n);
    check("t2_gnt2", o_gnt, 4'b0100);
    do_pkt(a, d);
    check("t2_ack2", a, 4'b0100);

    // Starvation promotion
    i_req = 4'b0101;
    for (int k = 0; k < 9; k++) begin
      wait_gnt(n);
      check("t3_gnt", o_gnt, (k < 8) ? 32'd1 : 32'd4);
      do_pkt(a, d);
      if (k < 8) i_req = i_req | 4'b0001;
    end

    // Same-cycle sop and eop
    wait_gnt(n);
    check("t4_gnt", o_gnt, 4'b0001);
    i_tx_sop = 1'b1;
    i_tx_eop = 1'b1;
    step();
    i_tx_sop = 1'b0;
    i_tx_eop = 1'b0;
    i_req = '0;
    check("t4_ack", o_ack, 4'b0001);
    check("t4_done", o_done, 4'b0001);
    check("t4_gnt_clr", o_gnt, 0);

    // Spurious sop during GAP
    step();
    i_tx_sop = 1'b1;
    step();
    i_tx_sop = 1'b0;
    check("gap_sop_err", o_err_cnt, 1);
    check("gap_sop_vld", o_gnt_vld, 0);
    check("gap_sop_ack", o_ack, 0);
    i_req = 4'b1000;
    step();
    check("gap_sop_err_hold", o_err_cnt, 1);
    wait_gnt(n);
    check("gap_unchanged", n, 14);

    // Watchdog in BUSY
    check("t5_gnt", o_gnt, 4'b1000);
    i_tx_sop = 1'b1;
    step();
    i_tx_sop = 1'b0;
    check("t5_ack", o_ack, 4'b1000);
    i_req = '0;
    n = 0;
    done_seen = 1'b0;
    while (!o_abort && n < WDOG + 50) begin
      step();
      n++;
      done_seen = done_seen | (|o_done);
    end
    check("t5_abort", o_abort, 1);
    check("t5_abort_time", (n >= WDOG) && (n <= WDOG + 2), 1);
    check("t5_gnt", o_gnt, 0);
    check("t5_vld", o_gnt_vld, 0);
    check("t5_err", o_err_cnt, 2);
    check("t5_no_done", done_seen, 0);
    step();
    check("t5_abort_pulse", o_abort, 0);

    // Mid-packet reset
    i_req = 4'b0010;
    wait_gnt(n);
    check("t6_gnt", o_gnt, 4'b0010);
    i_tx_sop = 1'b1;
    step();
    i_tx_sop = 1'b0;
    check("t6_ack", o_ack, 4'b0010);
    i_req = '0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_gnt", o_gnt, 0);
    check("t6_rst_vld", o_gnt_vld, 0);
    check("t6_rst_err", o_err_cnt, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    i_tx_eop = 1'b1;
    step();
    i_tx_eop = 1'b0;
    check("t6_late_done", o_done, 0);
    check("t6_late_err", o_err_cnt, 0);
    step();
    check("t6_late_vld", o_gnt_vld, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
